// File: rtl/alu_div_16_bit.sv
// ---------------------------------------------------------------------------
// alu_div_16_bit : iterative restoring divider, one quotient bit per clock
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_div_16_bit #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] dvnd_raw;
  logic [CW-1:0]    count;
  logic             neg_q;
  logic             neg_r;
  logic             dbz;

  logic [WIDTH-1:0] dvnd_mag;
  logic [WIDTH-1:0] dvsr_mag;
  logic [WIDTH-1:0] rem_sh;
  logic [WIDTH:0]   trial;

  always_comb begin
    dvnd_mag = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
    dvsr_mag = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;
    rem_sh   = {rem[WIDTH-2:0], quo[WIDTH-1]};
    // The extra top bit acts as the borrow: set means the trial went negative.
    trial    = {rem, quo[WIDTH-1]} - {1'b0, dvsr};
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      rem         <= '0;
      quo         <= '0;
      dvsr        <= '0;
      dvnd_raw    <= '0;
      count       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dbz         <= 1'b0;
      ready       <= 1'b1;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            dvnd_raw <= dividend;
            neg_q    <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r    <= signed_op & dividend[WIDTH-1];
            rem      <= '0;
            quo      <= dvnd_mag;
            dvsr     <= dvsr_mag;
            count    <= CW'(WIDTH);
            ready    <= 1'b0;
            if (divisor == '0) begin
              dbz   <= 1'b1;
              state <= FIX;
            end else begin
              dbz   <= 1'b0;
              state <= RUN;
            end
          end
        end

        RUN: begin
          if (!trial[WIDTH]) begin
            rem <= trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= rem_sh;
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          count <= count - 1'b1;
          if (count == CW'(1)) begin
            state <= FIX;
          end
        end

        FIX: begin
          if (dbz) begin
            quotient    <= '1;
            remainder   <= dvnd_raw;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= neg_q ? -quo : quo;
            remainder   <= neg_r ? -rem : rem;
            div_by_zero <= 1'b0;
          end
          done  <= 1'b1;
          ready <= 1'b1;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          ready <= 1'b1;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_div_16_bit.sv
// ---------------------------------------------------------------------------
// tb_alu_div_16_bit : scoreboard bench for the iterative divider
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_div_16_bit;

  logic        clock;
  logic        resetn;
  logic        start;
  logic        signed_op;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        ready;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  alu_div_16_bit #(.WIDTH(16)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int edge_cnt = 0;
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    int          edge_no;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (resetn && done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done at edge %0d, expected none", edge_cnt);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", {16'h0, quotient}, {16'h0, e.q});
        check("remainder", {16'h0, remainder}, {16'h0, e.r});
        check("div_by_zero", {31'h0, div_by_zero}, {31'h0, e.dbz});
        check("done_edge", edge_cnt, e.edge_no);
      end
    end
  end

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic issue(input logic s, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] eq, input logic [15:0] er, input logic ed,
                       input int lat, input bit push);
    int t;
    t = 0;
    while (!ready && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (!ready) begin
      check("ready_timeout", {31'h0, ready}, 32'h1);
    end
    signed_op = s;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(negedge clock);
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 16'($urandom);
    check("ready_low_after_accept", {31'h0, ready}, 32'h0);
    if (push) sb.push_back('{eq, er, ed, edge_cnt + lat});
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!done && t < 100) begin
      @(negedge clock);
      t++;
    end
    if (!done) check("done_timeout", {31'h0, done}, 32'h1);
  endtask

  initial begin
    int t;
    resetn    = 1'b0;
    start     = 1'b0;
    signed_op = 1'b0;
    dividend  = 16'h0;
    divisor   = 16'h0;
    repeat (3) @(negedge clock);
    check("reset_ready", {31'h0, ready}, 32'h1);
    check("reset_done", {31'h0, done}, 32'h0);
    check("reset_quotient", {16'h0, quotient}, 32'h0);
    check("reset_remainder", {16'h0, remainder}, 32'h0);
    check("reset_dbz", {31'h0, div_by_zero}, 32'h0);
    resetn = 1'b1;
    @(negedge clock);

    issue(1'b0, 16'd100,  16'd7,     16'd14,   16'd2,    1'b0, 17, 1'b1);
    issue(1'b1, 16'hFFF9, 16'h0002,  16'hFFFD, 16'hFFFF, 1'b0, 17, 1'b1);
    issue(1'b1, 16'h0007, 16'hFFFE,  16'hFFFD, 16'h0001, 1'b0, 17, 1'b1);
    issue(1'b1, 16'hFF9C, 16'hFFF9,  16'h000E, 16'hFFFE, 1'b0, 17, 1'b1);
    issue(1'b0, 16'h1234, 16'h0000,  16'hFFFF, 16'h1234, 1'b1, 1,  1'b1);
    issue(1'b1, 16'h1234, 16'h0000,  16'hFFFF, 16'h1234, 1'b1, 1,  1'b1);
    issue(1'b0, 16'hFFFF, 16'h0001,  16'hFFFF, 16'h0000, 1'b0, 17, 1'b1);
    issue(1'b1, 16'h8000, 16'hFFFF,  16'h8000, 16'h0000, 1'b0, 17, 1'b1);
    issue(1'b0, 16'h8000, 16'hFFFF,  16'h0000, 16'h8000, 1'b0, 17, 1'b1);

    // Starts during a run must be ignored.
    issue(1'b0, 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17, 1'b1);
    repeat (2) @(negedge clock);
    signed_op = 1'b1; dividend = 16'h4321; divisor = 16'h0000; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("ignored_start_ready", {31'h0, ready}, 32'h0);
    repeat (6) @(negedge clock);
    signed_op = 1'b0; dividend = 16'h0050; divisor = 16'h0003; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("ignored_start2_ready", {31'h0, ready}, 32'h0);
    wait_done();

    // Back-to-back: second op accepted in the done cycle of the first.
    issue(1'b0, 16'hFFFF, 16'h0010, 16'h0FFF, 16'h000F, 1'b0, 17, 1'b1);
    wait_done();
    issue(1'b1, 16'hFF9C, 16'h0007, 16'hFFF2, 16'hFFFE, 1'b0, 17, 1'b1);
    wait_done();
    @(negedge clock);

    // Asynchronous reset in the middle of a run aborts it.
    issue(1'b0, 16'h00FF, 16'h0003, 16'h0055, 16'h0000, 1'b0, 17, 1'b0);
    repeat (7) @(negedge clock);
    resetn = 1'b0;
    #1;
    check("midreset_quotient", {16'h0, quotient}, 32'h0);
    check("midreset_remainder", {16'h0, remainder}, 32'h0);
    check("midreset_done", {31'h0, done}, 32'h0);
    check("midreset_ready", {31'h0, ready}, 32'h1);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    check("post_reset_ready", {31'h0, ready}, 32'h1);
    repeat (20) @(negedge clock);
    issue(1'b0, 16'd1000, 16'd33, 16'd30, 16'd10, 1'b0, 17, 1'b1);

    t = 0;
    while (sb.size() > 0 && t < 2000) begin
      @(negedge clock);
      t++;
    end
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL missing_done: got no result, expected q=0x%0h r=0x%0h by edge %0d",
               e.q, e.r, e.edge_no);
    end
    repeat (5) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_div_16_bit.md
Name: alu_div_16_bit

Overview:
Iterative 16-bit integer divider: the shift-and-subtract counterpart to the ripple add/subtract ALU datapath. It sits beside the ALU in the execute stage and handles DIV/REM operations that the combinational ALU cannot. It accepts one operation per start pulse, runs one restoring-division step per clock, and returns quotient and remainder with a one-cycle done pulse.

Parameters:
WIDTH, 16, operand/result width in bits; the step counter is sized to hold WIDTH.

Ports:
clock  input  1  single clock; all state updates on the rising edge
resetn  input  1  asynchronous, active-low reset
start  input  1  request; sampled only when ready=1
signed_op  input  1  1 = two's-complement division, 0 = unsigned; captured with start
dividend  input  WIDTH  numerator; captured with start
divisor  input  WIDTH  denominator; captured with start
ready  output  1  1 in IDLE, so start can be accepted
done  output  1  one-cycle pulse; results valid in the same cycle
quotient  output  WIDTH  result quotient; held until the next done
remainder  output  WIDTH  result remainder; held until the next done
div_by_zero  output  1  flag for the last completed op; held with the results

Behaviour:
- Reset (resetn=0, async): state=IDLE, ready=1, done=0, quotient=0, remainder=0, div_by_zero=0, internal registers cleared. A reset mid-operation aborts it with no done pulse.
- States: IDLE, RUN, FIX.
- IDLE:
  - On an edge with start=1: capture operands and signed_op.
  - If divisor==0: go directly to FIX with the dbz flag set.
  - Otherwise: load |dividend| and |divisor| (magnitudes only when signed_op=1), clear the partial remainder, set count=WIDTH, go to RUN. ready falls in the following cycle.
- RUN, one step per edge:
  - Shift {rem,quo} left by 1.
  - Trial = rem - divisor magnitude, computed at WIDTH+1 bits.
  - If trial is non-negative: rem=trial and quo LSB=1; else quo LSB=0.
  - count decrements; after the step that takes count to 0, go to FIX.
- FIX, one edge: register the outputs, pulse done=1 for exactly one cycle, return to IDLE (ready=1 in that same cycle).
  - signed_op=1: quotient is negated if the signs of dividend and divisor differ (truncation toward zero). Remainder takes the sign of the dividend.
  - Overflow case -2^(WIDTH-1) / -1: quotient=0x8000, remainder=0 (natural wrap, no flag).
  - div_by_zero: quotient=all ones, remainder=dividend unchanged, div_by_zero=1, in both signed and unsigned modes.
- Latency, measured from the edge that accepts start to the edge that raises done:
  - Normal op: WIDTH+1 edges (17 for the default width).
  - Divide-by-zero: 1 edge.
- start is ignored when ready=0; no queuing. A new start is accepted in the same cycle done is high, because ready=1 then. Outputs stay stable except on a FIX edge. Operand inputs may change freely after capture.

Test Plan:
- Unsigned 100/7, start held for one cycle -> done exactly 17 edges later; quotient=14, remainder=2, div_by_zero=0.
- Signed -7/2 (0xFFF9/0x0002) -> quotient=0xFFFD, remainder=0xFFFF. Signed 7/-2 -> quotient=0xFFFD, remainder=0x0001.
- 0x1234/0 (unsigned and signed) -> done after 1 edge; quotient=0xFFFF, remainder=0x1234, div_by_zero=1. Then 0xFFFF/0x0001 unsigned -> quotient=0xFFFF, remainder=0, div_by_zero=0.
- Signed 0x8000/0xFFFF -> quotient=0x8000, remainder=0. Unsigned 0x8000/0xFFFF -> quotient=0, remainder=0x8000.
- start pulsed with new operands at edges 3 and 10 of a running op -> both ignored; the original result is unchanged. Back-to-back start in the done cycle -> accepted; second done 17 edges later.
- resetn asserted at edge 8 of a run -> outputs go to 0 immediately (asynchronously); no done pulse; ready=1 after release; next op completes correctly.
